// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan controller.
// HUB75_BCM_EN (optional macro) enables multi-plane binary-code modulation.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_e;

  // Colour field positions inside a framebuffer word {r0,g0,b0,r1,g1,b1}
  localparam int unsigned NUM_CH = 6;
  localparam int unsigned R0_F   = 5;
  localparam int unsigned G0_F   = 4;
  localparam int unsigned B0_F   = 3;
  localparam int unsigned R1_F   = 2;
  localparam int unsigned G1_F   = 1;
  localparam int unsigned B1_F   = 0;

  localparam int unsigned COLS_DEF      = 64;
  localparam int unsigned ROWS_HALF_DEF = 32;
  localparam int unsigned CLK_DIV_DEF   = 2;
  localparam int unsigned ON_TIME_DEF   = 64;
  localparam int unsigned BITS_DEF      = 4;

  // Counter width for n states; never narrower than one bit
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ROW_W_DEF     = width_of(ROWS_HALF_DEF);
  localparam int unsigned FB_ADDR_W_DEF = width_of(ROWS_HALF_DEF * COLS_DEF);
  localparam int unsigned FB_DATA_W_DEF = NUM_CH * BITS_DEF;

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Framebuffer read port plus panel pins of the HUB75 scan controller.
interface hub75_scan_ctrl_if
  import hub75_pkg::*;
#(
  parameter int unsigned FB_ADDR_W = FB_ADDR_W_DEF,
  parameter int unsigned FB_DATA_W = FB_DATA_W_DEF,
  parameter int unsigned ROW_W     = ROW_W_DEF
);
  logic                 fb_rd;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [FB_DATA_W-1:0] fb_data;
  logic                 r0, g0, b0, r1, g1, b1;
  logic [ROW_W-1:0]     addr;
  logic                 clk_out;
  logic                 latch;
  logic                 oe;

  modport master (
    output fb_rd, fb_addr, r0, g0, b0, r1, g1, b1, addr, clk_out, latch, oe,
    input  fb_data
  );

  modport slave (
    input  fb_rd, fb_addr, r0, g0, b0, r1, g1, b1, addr, clk_out, latch, oe,
    output fb_data
  );
endinterface

// File: rtl/hub75_shift_timer.sv
// Column phase counter for the SHIFT state: drives fb_rd and clk_out.
module hub75_shift_timer
  import hub75_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned PH_W    = width_of(2 * CLK_DIV)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            active_i,
  input  logic            last_col_i,
  output logic [PH_W-1:0] phase_o,
  output logic            fb_rd_o,
  output logic            clk_out_o
);

  localparam int unsigned PH_LAST = 2 * CLK_DIV - 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            fb_rd_q, clk_out_q;
  logic            at_last_c, more_c;

  // Next phase; more_c means the coming cycle is still a shift cycle
  always_comb begin
    at_last_c = active_i && (phase_q == PH_W'(PH_LAST));
    more_c    = start_i || (active_i && !(at_last_c && last_col_i));
    phase_d   = phase_q;
    if (start_i || at_last_c) begin
      phase_d = '0;
    end else if (active_i) begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  // Outputs are decoded from the phase they will accompany
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= '0;
      fb_rd_q   <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      fb_rd_q   <= more_c && (phase_d == '0);
      clk_out_q <= more_c && (phase_d >= PH_W'(CLK_DIV));
    end
  end

  assign phase_o   = phase_q;
  assign fb_rd_o   = fb_rd_q;
  assign clk_out_o = clk_out_q;

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/N-scan panel sequencer: fetch, shift, blank, latch, display per row.
// Optional macro HUB75_BCM_EN: binary-code modulation over all colour planes;
// otherwise only the MSB plane is shown with base on-time.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int unsigned COLS      = COLS_DEF,
  parameter int unsigned ROWS_HALF = ROWS_HALF_DEF,
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned ON_TIME   = ON_TIME_DEF,
  parameter int unsigned BITS      = BITS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               frame_done,
  hub75_scan_ctrl_if.master  bus
);

  localparam int unsigned COL_W = width_of(COLS);
  localparam int unsigned ROW_W = width_of(ROWS_HALF);
  localparam int unsigned PH_W  = width_of(2 * CLK_DIV);
`ifdef HUB75_BCM_EN
  localparam int unsigned PL_W   = width_of(BITS);
  localparam int unsigned MAX_ON = ON_TIME << (BITS - 1);
`else
  localparam int unsigned MAX_ON = ON_TIME;
`endif
  localparam int unsigned ON_W = $clog2(MAX_ON + 1);

  state_e               state_q;
  logic [ROW_W-1:0]     row_q, addr_q, row_nx_c;
  logic [COL_W-1:0]     col_q;
  logic [ON_W-1:0]      on_cnt_q, dur_c;
  logic [NUM_CH-1:0]    colour_q, bit_c;
  logic [ROW_W+COL_W-1:0] fb_addr_q;
  logic                 latch_q, oe_q, frame_done_q;
  logic [PH_W-1:0]      phase_c;
  logic                 fb_rd_c, clk_out_c;
  logic                 col_done_c, capture_c, last_col_c, disp_end_c;
  logic                 last_plane_c, start_c;
`ifdef HUB75_BCM_EN
  logic [PL_W-1:0]      plane_q;
`endif

  // Pick the active plane bit out of each colour field
  for (genvar k = 0; k < NUM_CH; k++) begin : g_fld
`ifdef HUB75_BCM_EN
    logic [BITS-1:0] fld;
    assign fld      = bus.fb_data[k*BITS +: BITS];
    assign bit_c[k] = fld[plane_q];
`else
    assign bit_c[k] = bus.fb_data[k*BITS + BITS - 1];
`endif
  end

  // Row/column/plane boundary decode
  always_comb begin
    col_done_c = (state_q == ST_SHIFT) && (phase_c == PH_W'(2 * CLK_DIV - 1));
    capture_c  = (state_q == ST_SHIFT) && (phase_c == PH_W'(1));
    last_col_c = (col_q == COL_W'(COLS - 1));
    row_nx_c   = (row_q == ROW_W'(ROWS_HALF - 1)) ? '0 : row_q + ROW_W'(1);
`ifdef HUB75_BCM_EN
    dur_c        = ON_W'(ON_TIME) << plane_q;
    last_plane_c = (plane_q == PL_W'(BITS - 1));
`else
    dur_c        = ON_W'(ON_TIME);
    last_plane_c = 1'b1;
`endif
    disp_end_c = (state_q == ST_DISPLAY) && (on_cnt_q == dur_c - ON_W'(1));
    // enable only matters once a row has shown all its planes
    start_c    = ((state_q == ST_IDLE) && enable) ||
                 (disp_end_c && (!last_plane_c || enable));
  end

  hub75_shift_timer #(
    .CLK_DIV (CLK_DIV),
    .PH_W    (PH_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_c),
    .active_i   (state_q == ST_SHIFT),
    .last_col_i (last_col_c),
    .phase_o    (phase_c),
    .fb_rd_o    (fb_rd_c),
    .clk_out_o  (clk_out_c)
  );

  // Scan FSM with registered panel and framebuffer outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      on_cnt_q     <= '0;
      colour_q     <= '0;
      addr_q       <= '0;
      latch_q      <= 1'b0;
      oe_q         <= 1'b1;
      fb_addr_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef HUB75_BCM_EN
      plane_q      <= '0;
`endif
    end else begin
      latch_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (capture_c) begin
        colour_q <= bit_c;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q   <= ST_SHIFT;
            col_q     <= '0;
            fb_addr_q <= {row_q, COL_W'(0)};
          end
        end
        ST_SHIFT: begin
          if (col_done_c) begin
            if (last_col_c) begin
              state_q <= ST_BLANK;
              addr_q  <= row_q;
            end else begin
              col_q     <= col_q + COL_W'(1);
              fb_addr_q <= {row_q, col_q + COL_W'(1)};
            end
          end
        end
        ST_BLANK: begin
          state_q <= ST_LATCH;
          latch_q <= 1'b1;
        end
        ST_LATCH: begin
          state_q  <= ST_DISPLAY;
          oe_q     <= 1'b0;
          on_cnt_q <= '0;
        end
        ST_DISPLAY: begin
          if (disp_end_c) begin
            oe_q     <= 1'b1;
            col_q    <= '0;
            on_cnt_q <= '0;
            if (!last_plane_c) begin
              state_q   <= ST_SHIFT;
              fb_addr_q <= {row_q, COL_W'(0)};
`ifdef HUB75_BCM_EN
              plane_q   <= plane_q + PL_W'(1);
`endif
            end else begin
              row_q        <= row_nx_c;
              fb_addr_q    <= {row_nx_c, COL_W'(0)};
              frame_done_q <= (row_q == ROW_W'(ROWS_HALF - 1));
              state_q      <= enable ? ST_SHIFT : ST_IDLE;
`ifdef HUB75_BCM_EN
              plane_q      <= '0;
`endif
            end
          end else begin
            on_cnt_q <= on_cnt_q + ON_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.fb_rd   = fb_rd_c;
  assign bus.fb_addr = fb_addr_q;
  assign bus.clk_out = clk_out_c;
  assign bus.latch   = latch_q;
  assign bus.oe      = oe_q;
  assign bus.addr    = addr_q;
  assign bus.r0      = colour_q[R0_F];
  assign bus.g0      = colour_q[G0_F];
  assign bus.b0      = colour_q[B0_F];
  assign bus.r1      = colour_q[R1_F];
  assign bus.g1      = colour_q[G1_F];
  assign bus.b1      = colour_q[B1_F];
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with a framebuffer model and scoreboard.
module tb_hub75_scan_ctrl;

  localparam int unsigned COLS      = 4;
  localparam int unsigned ROWS_HALF = 2;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned ON_TIME   = 8;
  localparam int unsigned BITS      = 4;
`ifdef HUB75_BCM_EN
  localparam int unsigned NPL = BITS;
`else
  localparam int unsigned NPL = 1;
`endif

  typedef struct {
    int sh;
    int row;
    bit last;
  } disp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic frame_done;
  logic [23:0] mem [8];

  hub75_scan_ctrl_if #(.FB_ADDR_W(3), .FB_DATA_W(24), .ROW_W(1)) bus ();

  hub75_scan_ctrl #(
    .COLS(COLS), .ROWS_HALF(ROWS_HALF), .CLK_DIV(CLK_DIV),
    .ON_TIME(ON_TIME), .BITS(BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .frame_done(frame_done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer: data one cycle after the read strobe
  always @(posedge clk) if (bus.fb_rd) bus.fb_data <= mem[bus.fb_addr];

  int vectors = 0, miscompares = 0;
  int cyc = 0, rd_cnt = 0, rise_cnt = 0, fd_cnt = 0, disp_cnt = 0;
  int low_cnt = 0, last_rise = 0, rise_idx = 0;
  int m_row = 0, m_col = 0, m_pass = 0;
  logic prev_oe = 1'b1, prev_clk = 1'b0, prev_latch = 1'b0;
  logic [5:0] q_col [$];
  disp_t q_disp [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_bits(input logic [23:0] w, input int b);
    logic [5:0] r;
    for (int k = 0; k < 6; k++) r[k] = w[k*BITS + b];
    return r;
  endfunction

  function automatic logic [5:0] dut_bits();
    return {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1};
  endfunction

  // One clock: sample at negedge, push expectations on reads, check on events
  task automatic tick();
    disp_t d;
    logic oe_rose;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      m_row = 0; m_col = 0; m_pass = 0; rise_idx = 0; low_cnt = 0;
      q_col.delete(); q_disp.delete();
      prev_oe = 1'b1; prev_clk = 1'b0; prev_latch = 1'b0;
      return;
    end
    if (bus.fb_rd) begin
      rd_cnt++;
      chk("fb_addr", 32'(bus.fb_addr), 32'(m_row*COLS + m_col));
      q_col.push_back(exp_bits(mem[m_row*COLS + m_col], (NPL == 1) ? BITS-1 : m_pass));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        q_disp.push_back('{sh: (NPL == 1) ? 0 : m_pass, row: m_row, last: (m_pass == NPL-1)});
        m_pass++;
        if (m_pass == NPL) begin
          m_pass = 0;
          m_row = (m_row + 1) % ROWS_HALF;
        end
      end
    end
    if (bus.clk_out && !prev_clk) begin
      rise_cnt++;
      if (q_col.size() == 0) chk("colour_q_empty", 32'(q_col.size()), 1);
      else chk("colour_at_rise", 32'(dut_bits()), 32'(q_col.pop_front()));
      if (rise_idx != 0) chk("clk_out_spacing", 32'(cyc - last_rise), 2*CLK_DIV);
      rise_idx = (rise_idx + 1) % COLS;
      last_rise = cyc;
    end
    if (bus.latch) chk("clk_out_at_latch", 32'(bus.clk_out), 0);
    if (!bus.oe && prev_oe) begin
      chk("latch_before_oe", 32'(prev_latch), 1);
      if (q_disp.size() == 0) chk("disp_q_empty", 32'(q_disp.size()), 1);
      else chk("row_addr", 32'(bus.addr), 32'(q_disp[0].row));
      low_cnt = 0;
    end
    if (!bus.oe) low_cnt++;
    oe_rose = bus.oe && !prev_oe;
    if (oe_rose && q_disp.size() != 0) begin
      d = q_disp.pop_front();
      disp_cnt++;
      chk("oe_low_width", 32'(low_cnt), ON_TIME << d.sh);
      chk("frame_done_at_end", 32'(frame_done), 32'(d.last && d.row == ROWS_HALF-1));
    end
    if (frame_done) begin
      fd_cnt++;
      if (!oe_rose) chk("frame_done_stray", 32'(frame_done), 0);
    end
    prev_oe = bus.oe; prev_clk = bus.clk_out; prev_latch = bus.latch;
  endtask

  initial begin
    int base, rd_hold;
    for (int i = 0; i < 8; i++)
      mem[i] = {4'hF, 4'(i), 4'(~i), 4'hF, 4'(i*3), 4'(i ^ 5)};

    // Reset held two cycles with enable high
    enable = 1'b1;
    tick(); tick();
    chk("rst_oe", 32'(bus.oe), 1);
    chk("rst_latch", 32'(bus.latch), 0);
    chk("rst_clk_out", 32'(bus.clk_out), 0);
    chk("rst_fb_rd", 32'(bus.fb_rd), 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_colour", 32'(dut_bits()), 0);
    rst_n = 1'b1;

    // First frame; frame_done shares its cycle with the next row's first read
    for (int i = 0; i < 3000 && fd_cnt < 1; i++) tick();
    chk("frame1_done", 32'(fd_cnt), 1);
    chk("frame1_reads", 32'(rd_cnt), ROWS_HALF*NPL*COLS + 1);
    chk("frame1_rises", 32'(rise_cnt), ROWS_HALF*NPL*COLS);
    chk("frame1_displays", 32'(disp_cnt), ROWS_HALF*NPL);

    for (int i = 0; i < 3000 && fd_cnt < 2; i++) tick();
    chk("frame2_done", 32'(fd_cnt), 2);

    // Row 0 is now shifting: drop enable, row 0 must still finish
    enable = 1'b0;
    base = disp_cnt;
    for (int i = 0; i < 3000 && disp_cnt < base + NPL; i++) tick();
    chk("drop_row0_displays", 32'(disp_cnt), base + NPL);
    rd_hold = rd_cnt;
    for (int i = 0; i < 60; i++) tick();
    chk("idle_no_reads", 32'(rd_cnt), 32'(rd_hold));
    chk("idle_oe", 32'(bus.oe), 1);
    chk("idle_no_display", 32'(disp_cnt), base + NPL);
    chk("idle_addr_row0", 32'(bus.addr), 0);

    // Resume (row 1), then reset in the middle of its display
    enable = 1'b1;
    for (int i = 0; i < 3000 && bus.oe; i++) tick();
    chk("resume_display", 32'(bus.oe), 0);
    chk("resume_row", 32'(bus.addr), 1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_oe", 32'(bus.oe), 1);
    chk("midrst_addr", 32'(bus.addr), 0);
    chk("midrst_fb_rd", 32'(bus.fb_rd), 0);
    chk("midrst_latch", 32'(bus.latch), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 50 && !bus.fb_rd; i++) tick();
    chk("restart_rd", 32'(bus.fb_rd), 1);
    chk("restart_addr", 32'(bus.fb_addr), 0);
    base = fd_cnt;
    for (int i = 0; i < 3000 && fd_cnt == base; i++) tick();
    chk("restart_frame_done", 32'(fd_cnt), base + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
